pipelined_main_decoder: RTL

- Next-generation main decoder for the 3-stage RV32I pipeline.
- Decodes opcode/funct3 in the decode stage and carries the control bundle through PIPE_DEPTH stall/flush-aware registers to the execute stage.
- Resolves branch/jump redirect (PCSrc) in execute from ALU flags.
- Adds I-type ALU, JAL and LUI support, full branch-condition decode and illegal-opcode detection.

---
 rtl/pipelined_main_decoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_main_decoder.sv
// pipelined_main_decoder: RV32I main decoder with a stall/flush-aware
// control pipe (PIPE_DEPTH stages) and execute-stage redirect.
//
// Parameters: PIPE_DEPTH (1..3), ENABLE_JUMP (1 = decode JAL).
// Optional macro MAIN_DEC_ILLEGAL_TRAP_EN adds illegal_sticky and
// illegal_count (8b saturating).
// Ports:
//   clk, rst (async, active low)
//   op, funct3, in_valid      decode-stage instruction
//   stall, flush              pipe control (flush wins)
//   zero, lt, ltu             execute-stage ALU flags
//   ImmSrc_D, illegal_D       decode-stage combinational outputs
//   valid_E, *_E              execute-stage control bundle
//   PCSrc                     combinational branch/jump redirect
module pipelined_main_decoder #(
  parameter int PIPE_DEPTH  = 1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       in_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic [2:0] ImmSrc_D,
  output logic       illegal_D,
  output logic       valid_E,
  output logic       RegWrite_E,
  output logic       MemWrite_E,
  output logic       ALUSrc_E,
  output logic       Branch_E,
  output logic       Jump_E,
  output logic [1:0] ResultSrc_E,
  output logic [1:0] ALUOp_E,
  output logic [2:0] funct3_E,
`ifdef MAIN_DEC_ILLEGAL_TRAP_EN
  output logic       illegal_sticky,
  output logic [7:0] illegal_count,
`endif
  output logic       PCSrc
);

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 3) begin : g_bad_depth
    $error("pipelined_main_decoder: PIPE_DEPTH must be 1..3");
  end

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
  } ctl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic w_load, w_store, w_r, w_i;
  logic w_br, w_jal, w_lui, w_legal;

  assign w_load  = (op == OP_LOAD);
  assign w_store = (op == OP_STORE);
  assign w_r     = (op == OP_R);
  assign w_i     = (op == OP_I);
  // funct3 010/011 has no branch encoding
  assign w_br    = (op == OP_BR) && (funct3[2:1] != 2'b01);
  assign w_jal   = ENABLE_JUMP && (op == OP_JAL);
  assign w_lui   = (op == OP_LUI);
  assign w_legal = w_load | w_store | w_r | w_i
                 | w_br | w_jal | w_lui;

  ctl_t       w_dec;
  logic [2:0] w_imm;

  always_comb begin
    w_dec = '0;
    w_imm = 3'b000;
    unique case (1'b1)
      w_load: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b01;
        w_dec.alu_src    = 1'b1;
      end
      w_store: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_imm           = 3'b001;
      end
      w_r: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = 2'b10;
      end
      w_i: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = 2'b10;
      end
      w_br: begin
        w_dec.alu_op = 2'b01;
        w_dec.branch = 1'b1;
        w_imm        = 3'b010;
      end
      w_jal: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.jump       = 1'b1;
        w_imm            = 3'b011;
      end
      w_lui: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = 2'b11;
        w_imm           = 3'b100;
      end
      default: ;
    endcase
  end

  assign ImmSrc_D  = w_imm;
  assign illegal_D = in_valid & ~w_legal;

  // Illegal ops still enter as valid, but with every control low
  ctl_t w_s1;
  always_comb begin
    w_s1        = in_valid ? w_dec : '0;
    w_s1.valid  = in_valid;
    w_s1.funct3 = in_valid ? funct3 : 3'b000;
  end

  ctl_t r_stage [PIPE_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++)
        r_stage[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < PIPE_DEPTH; k++)
        r_stage[k] <= '0;
    end else if (!stall) begin
      r_stage[0] <= w_s1;
      for (int k = 1; k < PIPE_DEPTH; k++)
        r_stage[k] <= r_stage[k-1];
    end
  end

  ctl_t w_e;
  assign w_e = r_stage[PIPE_DEPTH-1];

  assign valid_E     = w_e.valid;
  assign RegWrite_E  = w_e.reg_write;
  assign MemWrite_E  = w_e.mem_write;
  assign ALUSrc_E    = w_e.alu_src;
  assign Branch_E    = w_e.branch;
  assign Jump_E      = w_e.jump;
  assign ResultSrc_E = w_e.result_src;
  assign ALUOp_E     = w_e.alu_op;
  assign funct3_E    = w_e.funct3;

  logic w_cond;
  always_comb begin
    w_cond = 1'b0;
    case (w_e.funct3)
      3'b000:  w_cond = zero;
      3'b001:  w_cond = ~zero;
      3'b100:  w_cond = lt;
      3'b101:  w_cond = ~lt;
      3'b110:  w_cond = ltu;
      3'b111:  w_cond = ~ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign PCSrc = w_e.valid
               & (w_e.jump | (w_e.branch & w_cond));

`ifdef MAIN_DEC_ILLEGAL_TRAP_EN
  logic       w_trap;
  logic       r_sticky;
  logic [7:0] r_count;

  assign w_trap = illegal_D & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky <= 1'b0;
      r_count  <= 8'd0;
    end else if (w_trap) begin
      r_sticky <= 1'b1;
      if (r_count != 8'hFF)
        r_count <= r_count + 8'd1;
    end
  end

  assign illegal_sticky = r_sticky;
  assign illegal_count  = r_count;
`endif

endmodule
